product_accumulator: RTL

- Sequential stage directly downstream of the 8x8 combinational shift-add multiplier.
- Consumes its 16-bit product `R` as a stream of beats under a valid/ready handshake.
- Registers each product to break the multiplier's ripple path, then accumulates a group of beats that ends with `in_last` into a wide sum.
- Holds the group result, beat count and overflow flag until a downstream consumer accepts them; used for dot products and FIR taps built from the multiplier.

---
 rtl/product_acc_pkg.sv | 16 +
 rtl/acc_adder.sv | 26 ++
 rtl/product_accumulator.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/product_acc_pkg.sv
// Shared types and defaults for the product accumulator that sits behind
// the 8x8 shift-add multiplier.
package product_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } state_t;

  localparam int PROD_W            = 16;
  localparam int ACC_W_DEFAULT     = 24;
  localparam int MAX_BEATS_DEFAULT = 16;

endpackage

// File: rtl/acc_adder.sv
// ACC_W-bit accumulate of a zero-extended product with carry-out.
// Define PRODUCT_ACCUMULATOR_SAT_EN to clamp the sum on carry-out instead of wrapping.
module acc_adder
  import product_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, acc_i} + (ACC_W+1)'(prod_i);
  assign carry_o  = full_sum[ACC_W];

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  // A clamped acc carries again on any non-zero product, so it stays clamped.
  assign sum_o = carry_o ? '1 : full_sum[ACC_W-1:0];
`else
  assign sum_o = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Registers multiplier products and sums each in_last-terminated group, holding the
// result until consumed. Saturation is enabled with PRODUCT_ACCUMULATOR_SAT_EN.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter  int ACC_W     = ACC_W_DEFAULT,
  parameter  int MAX_BEATS = MAX_BEATS_DEFAULT,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              out_trunc,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t              state_q;
  logic                in_ready_q, out_valid_q;
  logic [PROD_W-1:0]   p_q, p_d;
  logic                p_vld_q, p_vld_d, p_last_q, p_last_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d, trunc_q, trunc_d;

  logic                accept, consume, at_max, close_grp, add_carry;
  logic [CNT_W-1:0]    cnt_inc;
  logic [ACC_W-1:0]    add_sum;

  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid_q & out_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign at_max    = (cnt_inc == CNT_W'(MAX_BEATS));
  assign close_grp = in_last | at_max;

  acc_adder #(.ACC_W(ACC_W)) u_adder (
    .acc_i   (acc_q),
    .prod_i  (p_q),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    p_d      = p_q;
    p_vld_d  = 1'b0;
    p_last_d = p_last_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    trunc_d  = trunc_q;
    if (accept) begin
      p_d      = in_prod;
      p_vld_d  = 1'b1;
      p_last_d = close_grp;
      cnt_d    = cnt_inc;
      trunc_d  = at_max & ~in_last;
    end
    if (p_vld_q) begin
      acc_d = add_sum;
      ovf_d = ovf_q | add_carry;
    end
    if (consume) begin
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      trunc_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q      <= '0;
      p_vld_q  <= 1'b0;
      p_last_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      p_q      <= p_d;
      p_vld_q  <= p_vld_d;
      p_last_q <= p_last_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      trunc_q  <= trunc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            if (close_grp) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DRAIN: begin
          if (p_vld_q && p_last_q) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;
  assign out_trunc = trunc_q;

endmodule
